traffic_light_gen: RTL and testbench

Cycle-accurate traffic-light sequence generator driving the one-hot `green`/`yellow`/`red` lamp signals that the light-sequence monitor consumes. It runs RED → GREEN → YELLOW → RED with parameterised phase lengths. On an external alarm it switches to a flashing-yellow safe mode. An optional fault-injection path produces illegal sequences so that monitor cheat/alarm detection can be exercised.

---
 rtl/traffic_light_gen_pkg.sv | 30 +++
 rtl/traffic_light_gen_if.sv | 29 ++
 rtl/traffic_light_gen_timer.sv | 33 +++
 rtl/traffic_light_gen.sv | 120 ++++++++++++
 tb/tb_traffic_light_gen.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_light_gen_pkg.sv
// rtl/traffic_light_gen_pkg.sv - shared types and constants for the traffic-light generator
// Package tl_pkg:
//   TIMER_W          width of the shared phase timer
//   *_T_DEF          default phase lengths in clock cycles
//   tl_state_t       state encoding, also driven out on the phase port
//   tl_successor()   normal-sequence successor RED -> GREEN -> YELLOW -> RED
package tl_pkg;

    localparam int TIMER_W        = 6;
    localparam int RED_T_DEF      = 20;
    localparam int GREEN_T_DEF    = 35;
    localparam int YELLOW_T_DEF   = 7;
    localparam int FLASH_HALF_DEF = 2;

    typedef enum logic [2:0] {
        RED    = 3'd0,
        GREEN  = 3'd1,
        YELLOW = 3'd2,
        FLASH  = 3'd3
    } tl_state_t;

    function automatic tl_state_t tl_successor(input tl_state_t s);
        case (s)
            RED:     return GREEN;
            GREEN:   return YELLOW;
            default: return RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_gen_if.sv
// rtl/traffic_light_gen_if.sv - control and lamp/status bundle of the traffic-light generator
// Signals:
//   enable, alarm, inject            controls toward the generator
//   green, yellow, red               lamp outputs
//   phase, timer, phase_done         state, remaining-cycles-minus-one, advance strobe
// Modports: master drives controls and observes lamps; slave is the generator side.
interface traffic_light_gen_if;

    logic                       enable;
    logic                       alarm;
    logic                       inject;
    logic                       green;
    logic                       yellow;
    logic                       red;
    logic [2:0]                 phase;
    logic [tl_pkg::TIMER_W-1:0] timer;
    logic                       phase_done;

    modport master (
        output enable, alarm, inject,
        input  green, yellow, red, phase, timer, phase_done
    );

    modport slave (
        input  enable, alarm, inject,
        output green, yellow, red, phase, timer, phase_done
    );

endinterface

// File: rtl/traffic_light_gen_timer.sv
// rtl/traffic_light_gen_timer.sv - loadable 6-bit down-counter shared by all light phases
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset (count returns to RST_VAL)
//   load, load_val   load has priority over counting
//   cnt_en           decrement by one when not loading
//   count, zero      current value and count==0 flag
module tl_timer
    import tl_pkg::*;
#(
    parameter logic [TIMER_W-1:0] RST_VAL = '0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               cnt_en,
    output logic [TIMER_W-1:0] count,
    output logic               zero
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (cnt_en) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/traffic_light_gen.sv
// rtl/traffic_light_gen.sv - RED/GREEN/YELLOW sequence generator with flashing-yellow alarm mode
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   bus (slave)      enable/alarm/inject in; green/yellow/red, phase, timer, phase_done out
// Parameters: RED_T, GREEN_T, YELLOW_T, FLASH_HALF, each 1..63 cycles.
// Macro TL_FAULT_INJECT_EN: when defined, inject in GREEN jumps straight to RED.
module traffic_light_gen
    import tl_pkg::*;
#(
    parameter int RED_T      = RED_T_DEF,
    parameter int GREEN_T    = GREEN_T_DEF,
    parameter int YELLOW_T   = YELLOW_T_DEF,
    parameter int FLASH_HALF = FLASH_HALF_DEF
) (
    input  logic                 clock,
    input  logic                 reset_n,
    traffic_light_gen_if.slave   bus
);

    if (RED_T < 1 || RED_T > 63 || GREEN_T < 1 || GREEN_T > 63 ||
        YELLOW_T < 1 || YELLOW_T > 63 || FLASH_HALF < 1 || FLASH_HALF > 63) begin : g_bad_param
        $error("traffic_light_gen: phase length parameter outside 1..63");
    end

    localparam logic [TIMER_W-1:0] RED_LD    = TIMER_W'(RED_T - 1);
    localparam logic [TIMER_W-1:0] GREEN_LD  = TIMER_W'(GREEN_T - 1);
    localparam logic [TIMER_W-1:0] YELLOW_LD = TIMER_W'(YELLOW_T - 1);
    localparam logic [TIMER_W-1:0] FLASH_LD  = TIMER_W'(FLASH_HALF - 1);

    tl_state_t          state, state_nxt;
    logic               flash, flash_nxt;
    logic               load, cnt_en, zero;
    logic [TIMER_W-1:0] load_val, count;
    logic               normal;
    logic               inject_hit;

    tl_timer #(.RST_VAL(RED_LD)) u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (load),
        .load_val (load_val),
        .cnt_en   (cnt_en),
        .count    (count),
        .zero     (zero)
    );

`ifdef TL_FAULT_INJECT_EN
    assign inject_hit = bus.inject && (state == GREEN);
`else
    logic unused_inject;
    assign unused_inject = bus.inject;
    assign inject_hit    = 1'b0;
`endif

    assign normal = (state == RED) || (state == GREEN) || (state == YELLOW);

    function automatic logic [TIMER_W-1:0] phase_len(input tl_state_t s);
        case (s)
            GREEN:   return GREEN_LD;
            YELLOW:  return YELLOW_LD;
            default: return RED_LD;
        endcase
    endfunction

    // Next-state and timer control, priority alarm > inject > timeout.
    // The FLASH half-period timer runs regardless of enable.
    always_comb begin
        state_nxt = state;
        flash_nxt = flash;
        load      = 1'b0;
        load_val  = count;
        cnt_en    = 1'b0;
        if (bus.alarm) begin
            state_nxt = FLASH;
            if (state != FLASH) begin
                flash_nxt = 1'b1;
                load      = 1'b1;
                load_val  = FLASH_LD;
            end else if (zero) begin
                flash_nxt = ~flash;
                load      = 1'b1;
                load_val  = FLASH_LD;
            end else begin
                cnt_en = 1'b1;
            end
        end else if (!normal || inject_hit) begin
            // FLASH exit, injected GREEN->RED skip, and unreachable encodings all land in RED.
            state_nxt = RED;
            flash_nxt = 1'b0;
            load      = 1'b1;
            load_val  = RED_LD;
        end else if (bus.enable) begin
            if (zero) begin
                state_nxt = tl_successor(state);
                load      = 1'b1;
                load_val  = phase_len(tl_successor(state));
            end else begin
                cnt_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= RED;
            flash <= 1'b0;
        end else begin
            state <= state_nxt;
            flash <= flash_nxt;
        end
    end

    assign bus.red        = (state == RED);
    assign bus.green      = (state == GREEN);
    assign bus.yellow     = (state == YELLOW) || ((state == FLASH) && flash);
    assign bus.phase      = state;
    assign bus.timer      = count;
    assign bus.phase_done = zero && bus.enable && normal && !bus.alarm && !inject_hit;

endmodule

// File: tb/tb_traffic_light_gen.sv
// tb/tb_traffic_light_gen.sv - scoreboard bench for traffic_light_gen with default parameters
module tb_traffic_light_gen;

    typedef struct packed {
        logic [2:0] ph;
        logic [5:0] tm;
        logic       r;
        logic       g;
        logic       y;
        logic       pd;
    } obs_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    obs_t exp_q[$];

    traffic_light_gen_if bus ();

    traffic_light_gen dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    function automatic obs_t mk(input int ph, input int tm, input bit pd, input bit fl);
        obs_t o;
        o.ph = 3'(ph);
        o.tm = 6'(tm);
        o.r  = (ph == 0);
        o.g  = (ph == 1);
        o.y  = (ph == 2) || (ph == 3 && fl);
        o.pd = pd;
        return o;
    endfunction

    // Expected value for cycle m of an undisturbed 62-cycle sequence after reset.
    function automatic obs_t nominal(input int m);
        if (m < 20)      return mk(0, 19 - m, m == 19, 1'b0);
        else if (m < 55) return mk(1, 54 - m, m == 54, 1'b0);
        else             return mk(2, 61 - m, m == 61, 1'b0);
    endfunction

    // Leaves the DUT just released at a falling edge: the current cycle is cycle 0.
    task automatic do_reset();
        @(negedge clock);
        reset_n    = 1'b0;
        bus.enable = 1'b1;
        bus.alarm  = 1'b0;
        bus.inject = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        @(negedge clock);
        reset_n    = 1'b0;
        bus.enable = 1'b0;
        bus.alarm  = 1'b0;
        bus.inject = 1'b0;
        exp_q.push_back(mk(0, 19, 1'b0, 1'b0));
        exp_q.push_back(mk(0, 19, 1'b0, 1'b0));
        #1;
        got = {bus.phase, bus.timer, bus.red, bus.green, bus.yellow, bus.phase_done};
        exp = exp_q.pop_front();
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL reset got ph=%0d tm=%0d rgyd=%b want ph=%0d tm=%0d rgyd=%b",
                     got.ph, got.tm, {got.r, got.g, got.y, got.pd}, exp.ph, exp.tm, {exp.r, exp.g, exp.y, exp.pd});
        end
        bus.alarm  = 1'b1;
        bus.enable = 1'b1;
        @(posedge clock);
        #1;
        got = {bus.phase, bus.timer, bus.red, bus.green, bus.yellow, bus.phase_done};
        exp = exp_q.pop_front();
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL reset_over_alarm got ph=%0d tm=%0d rgyd=%b want ph=%0d tm=%0d rgyd=%b",
                     got.ph, got.tm, {got.r, got.g, got.y, got.pd}, exp.ph, exp.tm, {exp.r, exp.g, exp.y, exp.pd});
        end
        bus.alarm = 1'b0;
    endtask

    task automatic test_sequence();
        obs_t got, exp;
        do_reset();
        for (int n = 0; n < 125; n++) exp_q.push_back(nominal(n % 62));
        for (int n = 0; n < 125; n++) begin
            #1;
            got = {bus.phase, bus.timer, bus.red, bus.green, bus.yellow, bus.phase_done};
            exp = exp_q.pop_front();
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL sequence n=%0d got ph=%0d tm=%0d rgyd=%b want ph=%0d tm=%0d rgyd=%b", n,
                         got.ph, got.tm, {got.r, got.g, got.y, got.pd}, exp.ph, exp.tm, {exp.r, exp.g, exp.y, exp.pd});
            end
            @(negedge clock);
        end
    endtask

    task automatic test_enable_hold();
        obs_t got, exp;
        do_reset();
        for (int n = 0; n < 73; n++) begin
            if (n < 42)      exp_q.push_back(nominal(n));
            else if (n < 52) exp_q.push_back(mk(1, 12, 1'b0, 1'b0));
            else if (n < 65) exp_q.push_back(mk(1, 64 - n, n == 64, 1'b0));
            else if (n < 72) exp_q.push_back(mk(2, 71 - n, n == 71, 1'b0));
            else             exp_q.push_back(mk(0, 19, 1'b0, 1'b0));
        end
        for (int n = 0; n < 73; n++) begin
            bus.enable = !(n >= 42 && n <= 51);
            #1;
            got = {bus.phase, bus.timer, bus.red, bus.green, bus.yellow, bus.phase_done};
            exp = exp_q.pop_front();
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL enable_hold n=%0d got ph=%0d tm=%0d rgyd=%b want ph=%0d tm=%0d rgyd=%b", n,
                         got.ph, got.tm, {got.r, got.g, got.y, got.pd}, exp.ph, exp.tm, {exp.r, exp.g, exp.y, exp.pd});
            end
            @(negedge clock);
        end
        bus.enable = 1'b1;
    endtask

    task automatic test_alarm_flash();
        obs_t got, exp;
        int   k;
        do_reset();
        for (int n = 0; n < 61; n++) begin
            k = n - 50;
            if (n < 50)      exp_q.push_back(nominal(n));
            else if (n < 59) exp_q.push_back(mk(3, (k % 2 == 0) ? 1 : 0, 1'b0, ((k >> 1) & 1) == 0));
            else             exp_q.push_back(mk(0, 19 - (n - 59), 1'b0, 1'b0));
        end
        for (int n = 0; n < 61; n++) begin
            bus.alarm = (n >= 49 && n <= 57);
            #1;
            got = {bus.phase, bus.timer, bus.red, bus.green, bus.yellow, bus.phase_done};
            exp = exp_q.pop_front();
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL alarm_flash n=%0d got ph=%0d tm=%0d rgyd=%b want ph=%0d tm=%0d rgyd=%b", n,
                         got.ph, got.tm, {got.r, got.g, got.y, got.pd}, exp.ph, exp.tm, {exp.r, exp.g, exp.y, exp.pd});
            end
            @(negedge clock);
        end
        bus.alarm = 1'b0;
    endtask

    task automatic test_async_reset();
        obs_t got, exp;
        do_reset();
        repeat (58) @(negedge clock);
        exp_q.push_back(mk(2, 3, 1'b0, 1'b0));
        exp_q.push_back(mk(0, 19, 1'b0, 1'b0));
        exp_q.push_back(mk(0, 19, 1'b0, 1'b0));
        #1;
        got = {bus.phase, bus.timer, bus.red, bus.green, bus.yellow, bus.phase_done};
        exp = exp_q.pop_front();
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL async_pre got ph=%0d tm=%0d rgyd=%b want ph=%0d tm=%0d rgyd=%b",
                     got.ph, got.tm, {got.r, got.g, got.y, got.pd}, exp.ph, exp.tm, {exp.r, exp.g, exp.y, exp.pd});
        end
        #2;
        reset_n = 1'b0;
        #1;
        got = {bus.phase, bus.timer, bus.red, bus.green, bus.yellow, bus.phase_done};
        exp = exp_q.pop_front();
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL async_now got ph=%0d tm=%0d rgyd=%b want ph=%0d tm=%0d rgyd=%b",
                     got.ph, got.tm, {got.r, got.g, got.y, got.pd}, exp.ph, exp.tm, {exp.r, exp.g, exp.y, exp.pd});
        end
        @(posedge clock);
        #1;
        got = {bus.phase, bus.timer, bus.red, bus.green, bus.yellow, bus.phase_done};
        exp = exp_q.pop_front();
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL async_held got ph=%0d tm=%0d rgyd=%b want ph=%0d tm=%0d rgyd=%b",
                     got.ph, got.tm, {got.r, got.g, got.y, got.pd}, exp.ph, exp.tm, {exp.r, exp.g, exp.y, exp.pd});
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_alarm_at_zero();
        obs_t got, exp;
        do_reset();
        for (int n = 0; n < 64; n++) begin
            if (n < 61)       exp_q.push_back(nominal(n));
            else if (n == 61) exp_q.push_back(mk(2, 0, 1'b0, 1'b0));
            else if (n == 62) exp_q.push_back(mk(3, 1, 1'b0, 1'b1));
            else              exp_q.push_back(mk(0, 19, 1'b0, 1'b0));
        end
        for (int n = 0; n < 64; n++) begin
            bus.alarm = (n == 61);
            #1;
            got = {bus.phase, bus.timer, bus.red, bus.green, bus.yellow, bus.phase_done};
            exp = exp_q.pop_front();
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL alarm_at_zero n=%0d got ph=%0d tm=%0d rgyd=%b want ph=%0d tm=%0d rgyd=%b", n,
                         got.ph, got.tm, {got.r, got.g, got.y, got.pd}, exp.ph, exp.tm, {exp.r, exp.g, exp.y, exp.pd});
            end
            @(negedge clock);
        end
        bus.alarm = 1'b0;
    endtask

    task automatic test_inject();
        obs_t got, exp;
        do_reset();
        for (int n = 0; n < 28; n++) begin
`ifdef TL_FAULT_INJECT_EN
            if (n <= 24) exp_q.push_back(nominal(n));
            else         exp_q.push_back(mk(0, 19 - (n - 25), 1'b0, 1'b0));
`else
            exp_q.push_back(nominal(n));
`endif
        end
        for (int n = 0; n < 28; n++) begin
            bus.inject = (n == 24);
            #1;
            got = {bus.phase, bus.timer, bus.red, bus.green, bus.yellow, bus.phase_done};
            exp = exp_q.pop_front();
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL inject n=%0d got ph=%0d tm=%0d rgyd=%b want ph=%0d tm=%0d rgyd=%b", n,
                         got.ph, got.tm, {got.r, got.g, got.y, got.pd}, exp.ph, exp.tm, {exp.r, exp.g, exp.y, exp.pd});
            end
            @(negedge clock);
        end
        bus.inject = 1'b0;
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.alarm  = 1'b0;
        bus.inject = 1'b0;
        test_reset();
        test_sequence();
        test_enable_hold();
        test_alarm_flash();
        test_async_reset();
        test_alarm_at_zero();
        test_inject();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
